lifo_stack: RTL and testbench

//   Parametrised LIFO for the processor core (call/return and operand stacks).
//   - Generalises the fixed 8-bit, 2-deep stack: any width and depth.
//   - Adds occupancy count, full/empty flags and defined same-cycle push+pop.
//   - Top of stack is held in a register, so pop-then-use needs no read bubble.

---
 rtl/lifo_stack.sv | 99 +++++++++
 tb/tb_lifo_stack.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO with registered top of stack
// Optional sticky overflow/underflow flags are built when STACK_ERR_EN is defined.
module lifo_stack #(
  parameter int NBITS = 8,
  parameter int DEPTH = 8,
  localparam int NADDR = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [NBITS-1:0] in,
  output logic [NBITS-1:0] out,
  output logic [NADDR-1:0] count,
  output logic             empty,
  output logic             full,
  input  logic             err_clr,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

  // Entries below the top; the top itself lives in the out register.
  logic [NBITS-1:0] mem [DEPTH-1];

  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic             ovf_ev;
  logic             unf_ev;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [NBITS-1:0] out_nxt;
  logic [NADDR-1:0] count_nxt;

  // push+pop on an empty stack degenerates to a plain push.
  assign do_push = push & (~pop | empty) & ~full;
  assign do_repl = push & pop & ~empty;
  assign do_pop  = pop & ~push & ~empty;
  assign ovf_ev  = push & ~pop & full;
  assign unf_ev  = pop & ~push & empty;

  assign wr_idx = AW'(count - NADDR'(1));
  assign rd_idx = AW'(count - NADDR'(2));

  always_comb begin
    out_nxt   = out;
    count_nxt = count;
    if (do_push) begin
      out_nxt   = in;
      count_nxt = count + NADDR'(1);
    end else if (do_repl) begin
      out_nxt = in;
    end else if (do_pop) begin
      out_nxt   = (count == NADDR'(1)) ? '0 : mem[rd_idx];
      count_nxt = count - NADDR'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      out   <= out_nxt;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == NADDR'(DEPTH));
    end
  end

  // Storage is not reset; a slot is always written before it can be read.
  always_ff @(posedge clk) begin
    if (do_push && !empty)
      mem[wr_idx] <= out;
  end

`ifdef STACK_ERR_EN
  // A new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_ev | (ovf & ~err_clr);
      unf <= unf_ev | (unf & ~err_clr);
    end
  end
`else
  logic unused_err;
  assign unused_err = err_clr | ovf_ev | unf_ev;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed and randomized checks of lifo_stack against a queue model
module tb_lifo_stack;

  localparam int NBITS = 8;
  localparam int DEPTH = 4;
  localparam int NADDR = $clog2(DEPTH + 1);
`ifdef STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [NBITS-1:0] in = '0;
  logic [NBITS-1:0] out;
  logic [NADDR-1:0] count;
  logic             empty;
  logic             full;
  logic             err_clr = 1'b0;
  logic             ovf;
  logic             unf;

  lifo_stack #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .in(in),
    .out(out), .count(count), .empty(empty), .full(full),
    .err_clr(err_clr), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [NBITS-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NBITS-1:0] m_top();
    return (q.size() > 0) ? q[q.size()-1] : '0;
  endfunction

  task automatic m_update(input bit p, input bit po, input logic [NBITS-1:0] d, input bit c);
    bit oe, ue;
    oe = p && !po && (q.size() == DEPTH);
    ue = po && !p && (q.size() == 0);
    if (p && (!po || q.size() == 0)) begin
      if (q.size() < DEPTH) q.push_back(d);
    end else if (p && po) begin
      q[q.size()-1] = d;
    end else if (po && q.size() > 0) begin
      void'(q.pop_back());
    end
    if (ERR) begin
      if (c) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (oe) m_ovf = 1'b1;
      if (ue) m_unf = 1'b1;
    end
  endtask

  task automatic step(input bit p, input bit po, input logic [NBITS-1:0] d, input bit c);
    @(negedge clk);
    push = p; pop = po; in = d; err_clr = c;
    @(posedge clk);
    m_update(p, po, d, c);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out", 32'(out), 32'(m_top()));
      check("count", 32'(count), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("unf", 32'(unf), 32'(m_unf));
    end
  end

  logic [NBITS-1:0] pops_exp [4];

  initial begin
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_out", 32'(out), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_flags", 32'({ovf, unf}), 0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    step(1, 0, 8'hA1, 0); step(1, 0, 8'hB2, 0);
    step(1, 0, 8'hC3, 0); step(1, 0, 8'hD4, 0);
    check("t1_out", 32'(out), 32'h D4);
    check("t1_count", 32'(count), 4);
    check("t1_full", 32'(full), 1);
    pops_exp[0] = 8'hC3; pops_exp[1] = 8'hB2; pops_exp[2] = 8'hA1; pops_exp[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h00, 0);
      check("t1_pop_out", 32'(out), 32'(pops_exp[i]));
      check("t1_pop_count", 32'(count), 32'(3 - i));
    end
    check("t1_empty", 32'(empty), 1);

    step(1, 0, 8'hA1, 0); step(1, 0, 8'hB2, 0);
    step(1, 0, 8'hC3, 0); step(1, 0, 8'hD4, 0);
    step(1, 0, 8'h55, 0);
    check("t2_out", 32'(out), 32'h D4);
    check("t2_count", 32'(count), 4);
    check("t2_ovf", 32'(ovf), 32'(ERR));
    step(0, 1, 8'h00, 0);
    check("t2_pop_out", 32'(out), 32'h C3);
    step(0, 1, 8'h00, 0); step(0, 1, 8'h00, 0);
    check("t2_bottom", 32'(out), 32'h A1);
    step(0, 1, 8'h00, 1);

    step(0, 1, 8'h00, 0);
    check("t3_out", 32'(out), 0);
    check("t3_count", 32'(count), 0);
    check("t3_unf", 32'(unf), 32'(ERR));
    step(0, 0, 8'h00, 1);
    check("t3_clr", 32'(unf), 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 1);
    check("t3_set_wins", 32'(unf), 32'(ERR));
    step(0, 0, 8'h00, 1);

    step(1, 0, 8'h11, 0); step(1, 0, 8'h22, 0);
    step(1, 1, 8'h99, 0);
    check("t4_repl_out", 32'(out), 32'h 99);
    check("t4_repl_count", 32'(count), 2);
    step(0, 1, 8'h00, 0);
    check("t4_pop_out", 32'(out), 32'h 11);
    step(0, 1, 8'h00, 0);
    step(1, 1, 8'h7E, 0);
    check("t4_empty_pp_out", 32'(out), 32'h 7E);
    check("t4_empty_pp_count", 32'(count), 1);
    check("t4_empty_pp_unf", 32'(unf), 0);
    step(0, 1, 8'h00, 0);

    step(1, 0, 8'h01, 0); step(1, 0, 8'h02, 0); step(1, 0, 8'h03, 0);
    @(negedge clk);
    push = 1'b1; pop = 1'b0; in = 8'h44;
    #2;
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check("t5_count", 32'(count), 0);
    check("t5_out", 32'(out), 0);
    check("t5_empty", 32'(empty), 1);
    check("t5_flags", 32'({ovf, unf}), 0);
    @(negedge clk);
    push = 1'b0;
    rst = 1'b1;
    step(0, 1, 8'h00, 0);
    check("t5_unf", 32'(unf), 32'(ERR));
    step(0, 0, 8'h00, 1);

    for (int i = 0; i < 600; i++) begin
      bit hi, p, po, c;
      logic [NBITS-1:0] d;
      hi = ((i / 40) % 2) == 0;
      p  = $urandom_range(0, 99) < (hi ? 70 : 25);
      po = $urandom_range(0, 99) < (hi ? 25 : 70);
      c  = $urandom_range(0, 15) == 0;
      d  = NBITS'($urandom);
      step(p, po, d, c);
    end

    @(negedge clk);
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
